// File: rtl/fsk_demod.sv
// Two-tone FSK demodulator: measures rise-to-rise periods of fsk_in, classifies
// long periods as 1, debounces the decision and flags carrier loss.
// Optional input synchronizer enabled by defining FSK_DEMOD_SYNC_EN.
module fsk_demod #(
  parameter int CNT_W   = 8,
  parameter int THRESH  = 12,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fsk_in,
  output logic             m_ser_code_out,
  output logic             code_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             carrier_lost
);

  localparam int AGR_W = $clog2(CONFIRM) + 1;

  localparam logic [CNT_W-1:0] ThreshC  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [AGR_W-1:0] ConfirmC = AGR_W'(CONFIRM);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StTrack = 1'b1;

  logic             in_s;
  logic             cur_q, cur_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             cand_q, cand_d;
  logic [AGR_W-1:0] agree_q, agree_d;
  logic             ser_q, ser_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             lost_q, lost_d;
  logic             rise;
  logic             cls;

`ifdef FSK_DEMOD_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], fsk_in};
    in_s   = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  always_comb begin
    in_s = fsk_in;
  end
`endif

  always_comb begin
    cur_d  = in_s;
    prev_d = cur_q;
    rise   = cur_q & ~prev_q;

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    agree_d  = agree_q;
    ser_d    = ser_q;
    valid_d  = 1'b0;
    period_d = period_q;
    lost_d   = lost_q;
    cls      = 1'b0;

    case (state_q)
      StIdle: begin
        // The first edge only establishes a reference; no period yet.
        if (rise) begin
          state_d = StTrack;
          lost_d  = 1'b0;
        end
      end
      StTrack: begin
        if (rise) begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          cls      = (cnt_q > ThreshC);
          if (cls == cand_q) begin
            agree_d = (agree_q >= ConfirmC) ? ConfirmC : agree_q + AGR_W'(1);
          end else begin
            cand_d  = cls;
            agree_d = AGR_W'(1);
          end
          if (agree_d == ConfirmC) begin
            ser_d = cand_d;
          end
        end else if (cnt_q == TimeoutC) begin
          // Output bit holds across a dropout; only the debounce restarts.
          state_d = StIdle;
          lost_d  = 1'b1;
          agree_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      state_q  <= StIdle;
      cand_q   <= 1'b0;
      agree_q  <= '0;
      ser_q    <= 1'b0;
      valid_q  <= 1'b0;
      period_q <= '0;
      lost_q   <= 1'b1;
    end else begin
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      agree_q  <= agree_d;
      ser_q    <= ser_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      lost_q   <= lost_d;
    end
  end

  assign m_ser_code_out = ser_q;
  assign code_valid     = valid_q;
  assign period_out     = period_q;
  assign carrier_lost   = lost_q;

endmodule
